// File: rtl/spg_sched.sv
`default_nettype none
// ============================================================================
// Module   : spg_sched
// Brief    : Sequencer for the UKF sigma-point generator. Streams S columns
//            into the generator and routes results into the sigma buffer.
// Revision : 1.0
// ============================================================================
module spg_sched #(
    parameter int                N_STATE   = 6,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] GAMMA_RST = 32'h0300_0000,
    parameter int                SAW       = $clog2(N_STATE),
    parameter int                PAW       = $clog2(2*N_STATE+1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N_STATE*DATA_W-1:0]   x_in,
    input  logic                        cfg_gamma_we,
    input  logic [DATA_W-1:0]           cfg_gamma,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        s_rd_en,
    output logic [SAW-1:0]              s_rd_addr,
    input  logic [N_STATE*DATA_W-1:0]   s_rd_data,
    output logic                        spg_en,
    output logic [DATA_W-1:0]           spg_gamma,
    output logic [N_STATE*DATA_W-1:0]   spg_x,
    output logic [N_STATE*DATA_W-1:0]   spg_s,
    input  logic                        spg_valid,
    input  logic [N_STATE*DATA_W-1:0]   spg_sp1,
    input  logic [N_STATE*DATA_W-1:0]   spg_sp2,
    output logic                        sp_wr_en_a,
    output logic [PAW-1:0]              sp_wr_addr_a,
    output logic [N_STATE*DATA_W-1:0]   sp_wr_data_a,
    output logic                        sp_wr_en_b,
    output logic [PAW-1:0]              sp_wr_addr_b,
    output logic [N_STATE*DATA_W-1:0]   sp_wr_data_b
);

    localparam logic [2:0] c_ST_FLUSH = 3'd0;
    localparam logic [2:0] c_ST_IDLE  = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_RUN   = 3'd3;
    localparam logic [2:0] c_ST_DRAIN = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [SAW-1:0] c_K_LAST  = SAW'(N_STATE-1);
    localparam logic [PAW-1:0] c_ADDR_N  = PAW'(N_STATE);
    localparam logic [PAW-1:0] c_ADDR_2N = PAW'(2*N_STATE);

    logic [2:0]                  r_state;
    logic [SAW-1:0]              r_k;
    logic [N_STATE*DATA_W-1:0]   r_x;
    logic [DATA_W-1:0]           r_gamma;
    logic                        r_err;

    logic w_load, w_run, w_drain, w_pair;

    assign w_load  = (r_state == c_ST_LOAD);
    assign w_run   = (r_state == c_ST_RUN);
    assign w_drain = (r_state == c_ST_DRAIN);
    // Column k-1 result arrives while RUN is at k; the last column lands in DRAIN.
    assign w_pair  = (w_run && (r_k != '0)) || w_drain;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FLUSH;
            r_k     <= '0;
            r_x     <= '0;
            r_gamma <= GAMMA_RST;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_FLUSH: r_state <= c_ST_IDLE;
                c_ST_IDLE: begin
                    if (cfg_gamma_we) r_gamma <= cfg_gamma;
                    if (start) begin
                        r_x     <= x_in;
                        r_err   <= 1'b0;
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_k     <= '0;
                    r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    r_k <= r_k + SAW'(1);
                    if (r_k == c_K_LAST) r_state <= c_ST_DRAIN;
                end
                c_ST_DRAIN: r_state <= c_ST_DONE;
                c_ST_DONE:  r_state <= c_ST_IDLE;
                default:    r_state <= c_ST_FLUSH;
            endcase
            if (w_pair && !spg_valid) r_err <= 1'b1;
        end
    end

    always_comb begin
        busy         = (r_state != c_ST_IDLE);
        done         = (r_state == c_ST_DONE);
        err          = r_err;
        spg_en       = w_load || w_run;
        s_rd_en      = w_load || (w_run && (r_k != c_K_LAST));
        s_rd_addr    = w_load ? '0 : (r_k + SAW'(1));
        spg_gamma    = r_gamma;
        spg_x        = r_x;
        spg_s        = s_rd_data;
        sp_wr_en_a   = w_load || w_pair;
        sp_wr_addr_a = w_load ? '0 : (w_drain ? c_ADDR_N : PAW'(r_k));
        sp_wr_data_a = w_load ? r_x : spg_sp1;
        sp_wr_en_b   = w_pair;
        sp_wr_addr_b = w_drain ? c_ADDR_2N : (PAW'(r_k) + c_ADDR_N);
        sp_wr_data_b = spg_sp2;
    end

endmodule
`default_nettype wire

// File: tb/tb_spg_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_spg_sched
// Brief    : Randomized self-checking bench for spg_sched with behavioural
//            S memory, sigma-point generator and sigma buffer models.
// Revision : 1.0
// ============================================================================
module tb_spg_sched;

    localparam int N   = 6;
    localparam int W   = 32;
    localparam int VW  = N*W;
    localparam int NSP = 2*N+1;
    localparam int SAW = $clog2(N);
    localparam int PAW = $clog2(NSP);
    localparam logic [W-1:0] ONE  = 32'h0100_0000;
    localparam logic [W-1:0] G_RST = 32'h0300_0000;

    logic            clk = 1'b0;
    logic            rst, start, cfg_gamma_we;
    logic [VW-1:0]   x_in;
    logic [W-1:0]    cfg_gamma;
    logic            busy, done, err, s_rd_en, spg_en, spg_valid;
    logic [SAW-1:0]  s_rd_addr;
    logic [VW-1:0]   s_rd_data = '0;
    logic [W-1:0]    spg_gamma;
    logic [VW-1:0]   spg_x, spg_s;
    logic [VW-1:0]   spg_sp1 = '0;
    logic [VW-1:0]   spg_sp2 = '0;
    logic            sp_wr_en_a, sp_wr_en_b;
    logic [PAW-1:0]  sp_wr_addr_a, sp_wr_addr_b;
    logic [VW-1:0]   sp_wr_data_a, sp_wr_data_b;

    always #5 clk = ~clk;

    spg_sched #(
        .N_STATE(N), .DATA_W(W), .GAMMA_RST(G_RST), .SAW(SAW), .PAW(PAW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in),
        .cfg_gamma_we(cfg_gamma_we), .cfg_gamma(cfg_gamma),
        .busy(busy), .done(done), .err(err),
        .s_rd_en(s_rd_en), .s_rd_addr(s_rd_addr), .s_rd_data(s_rd_data),
        .spg_en(spg_en), .spg_gamma(spg_gamma), .spg_x(spg_x), .spg_s(spg_s),
        .spg_valid(spg_valid), .spg_sp1(spg_sp1), .spg_sp2(spg_sp2),
        .sp_wr_en_a(sp_wr_en_a), .sp_wr_addr_a(sp_wr_addr_a), .sp_wr_data_a(sp_wr_data_a),
        .sp_wr_en_b(sp_wr_en_b), .sp_wr_addr_b(sp_wr_addr_b), .sp_wr_data_b(sp_wr_data_b)
    );

    int            cyc = 0;
    logic [VW-1:0] s_mem   [0:7];
    logic [VW-1:0] buf_mem [0:15];
    int            wr_cyc  [0:15];
    bit            wr_seen [0:15];
    int            wr_cnt = 0, dup_cnt = 0, done_cnt = 0, done_cyc = -1;
    logic          gen_v1 = 1'b0, gen_v2 = 1'b0;
    logic          kill_valid, clr_buf;
    int            n_chk = 0, n_fail = 0;

    // Q8.24 signed multiply
    function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return W'(p >>> 24);
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int j = 0; j < N; j++) v[j*W +: W] = $urandom;
        return v;
    endfunction

    // Sigma point a, element j: x, x + g*S[:,a-1], x - g*S[:,a-1-N]
    function automatic logic [W-1:0] ref_elem(input int a, input int j,
                                              input logic [VW-1:0] x, input logic [W-1:0] g);
        logic [W-1:0] xj;
        xj = x[j*W +: W];
        if (a == 0) return xj;
        if (a <= N) return xj + fmul(g, s_mem[a-1][j*W +: W]);
        return xj - fmul(g, s_mem[a-1-N][j*W +: W]);
    endfunction

    // Generator emits one trailing valid after its enable drops.
    assign spg_valid = (gen_v1 | gen_v2) & ~kill_valid;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (s_rd_en) s_rd_data <= s_mem[s_rd_addr];
        gen_v1 <= spg_en;
        gen_v2 <= gen_v1;
        if (spg_en) begin
            for (int j = 0; j < N; j++) begin
                spg_sp1[j*W +: W] <= spg_x[j*W +: W] + fmul(spg_gamma, spg_s[j*W +: W]);
                spg_sp2[j*W +: W] <= spg_x[j*W +: W] - fmul(spg_gamma, spg_s[j*W +: W]);
            end
        end
        if (clr_buf) begin
            wr_cnt   <= 0;
            dup_cnt  <= 0;
            done_cnt <= 0;
            done_cyc <= -1;
            for (int a = 0; a < 16; a++) begin
                wr_seen[a] <= 1'b0;
                wr_cyc[a]  <= -1;
            end
        end else begin
            if (sp_wr_en_a) begin
                buf_mem[sp_wr_addr_a] <= sp_wr_data_a;
                wr_cyc[sp_wr_addr_a]  <= cyc;
                wr_seen[sp_wr_addr_a] <= 1'b1;
                if (wr_seen[sp_wr_addr_a]) dup_cnt <= dup_cnt + 1;
            end
            if (sp_wr_en_b) begin
                buf_mem[sp_wr_addr_b] <= sp_wr_data_b;
                wr_cyc[sp_wr_addr_b]  <= cyc;
                wr_seen[sp_wr_addr_b] <= 1'b1;
                if (wr_seen[sp_wr_addr_b]) dup_cnt <= dup_cnt + 1;
            end
            wr_cnt <= wr_cnt + int'(sp_wr_en_a) + int'(sp_wr_en_b);
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [VW-1:0] x, output int t0);
        x_in    = x;
        start   = 1'b1;
        clr_buf = 1'b1;
        t0      = cyc;
        @(posedge clk);
        #1;
        start   = 1'b0;
        clr_buf = 1'b0;
        x_in    = rand_vec();
    endtask

    task automatic check_run(input string tag, input logic [VW-1:0] x, input logic [W-1:0] g,
                             input int t0, input logic exp_err);
        check({tag, ".writes"},   64'(wr_cnt),   64'(NSP));
        check({tag, ".dup"},      64'(dup_cnt),  64'd0);
        check({tag, ".done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, ".done_cyc"}, 64'(done_cyc), 64'(t0 + N + 3));
        check({tag, ".err"},      64'(err),      64'(exp_err));
        check({tag, ".busy"},     64'(busy),     64'd0);
        for (int a = 0; a < NSP; a++) begin
            check($sformatf("%s.wcyc%0d", tag, a), 64'(wr_cyc[a]),
                  64'((a == 0) ? t0 + 1 : t0 + 3 + ((a - 1) % N)));
            for (int j = 0; j < N; j++)
                check($sformatf("%s.sp%0d[%0d]", tag, a, j),
                      64'(buf_mem[a][j*W +: W]), 64'(ref_elem(a, j, x, g)));
        end
    endtask

    initial begin
        int            t0;
        logic [VW-1:0] xv;
        logic [W-1:0]  g_ref, g_new;

        rst = 1'b1; start = 1'b0; cfg_gamma_we = 1'b0; cfg_gamma = G_RST;
        x_in = '0; kill_valid = 1'b0; clr_buf = 1'b0;
        for (int c = 0; c < 8; c++) s_mem[c] = '0;
        for (int a = 0; a < 16; a++) buf_mem[a] = '0;

        wait_cyc(3);
        check("rst.spg_en", 64'(spg_en),     64'd0);
        check("rst.done",   64'(done),       64'd0);
        check("rst.wr_a",   64'(sp_wr_en_a), 64'd0);
        check("rst.err",    64'(err),        64'd0);
        rst = 1'b0;
        wait_cyc(2);
        check("idle.busy",  64'(busy),       64'd0);
        check("idle.done",  64'(done),       64'd0);
        check("idle.err",   64'(err),        64'd0);
        check("idle.gamma", 64'(spg_gamma),  64'(G_RST));
        check("idle.wr_a",  64'(sp_wr_en_a), 64'd0);
        check("idle.wr_b",  64'(sp_wr_en_b), 64'd0);
        check("idle.rd",    64'(s_rd_en),    64'd0);

        // Directed: x = 1.0, S = 0.5*I, gamma = 3.0
        g_ref = G_RST;
        xv = {N{ONE}};
        for (int c = 0; c < N; c++) begin
            s_mem[c] = '0;
            s_mem[c][c*W +: W] = 32'h0080_0000;
        end
        launch(xv, t0);
        check("t1.busy_load", 64'(busy),         64'd1);
        check("t1.wr_a_load", 64'(sp_wr_en_a),   64'd1);
        check("t1.addr_load", 64'(sp_wr_addr_a), 64'd0);
        check("t1.spg_x0",    64'(spg_x[W-1:0]), 64'(ONE));
        wait_cyc(N + 5);
        check_run("t1", xv, g_ref, t0, 1'b0);
        check("t1.sp1[0]", 64'(buf_mem[1][W-1:0]),   64'h0280_0000);
        check("t1.sp7[0]", 64'(buf_mem[7][W-1:0]),   64'hFF80_0000);
        check("t1.sp1[1]", 64'(buf_mem[1][2*W-1:W]), 64'(ONE));

        // start held high: one run, then re-accepted at T+10
        x_in = xv; start = 1'b1; clr_buf = 1'b1; t0 = cyc;
        @(posedge clk);
        #1 clr_buf = 1'b0;
        wait_cyc(9);
        check("t2.busy_idle", 64'(busy),     64'd0);
        check("t2.done_cnt",  64'(done_cnt), 64'd1);
        check("t2.writes",    64'(wr_cnt),   64'(NSP));
        check("t2.done_cyc",  64'(done_cyc), 64'(t0 + N + 3));
        clr_buf = 1'b1; t0 = cyc;
        @(posedge clk);
        #1 clr_buf = 1'b0; start = 1'b0;
        check("t2.busy_rerun", 64'(busy), 64'd1);
        wait_cyc(N + 5);
        check_run("t2b", xv, g_ref, t0, 1'b0);

        // Reset mid-run, then a clean run with random S
        for (int c = 0; c < N; c++) s_mem[c] = rand_vec();
        launch(rand_vec(), t0);
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("t3.flush_busy", 64'(busy),       64'd1);
        check("t3.flush_en",   64'(spg_en),     64'd0);
        check("t3.flush_rd",   64'(s_rd_en),    64'd0);
        check("t3.flush_wra",  64'(sp_wr_en_a), 64'd0);
        check("t3.flush_wrb",  64'(sp_wr_en_b), 64'd0);
        check("t3.flush_done", 64'(done),       64'd0);
        wait_cyc(1);
        check("t3.idle_busy",  64'(busy),       64'd0);
        check("t3.no_done",    64'(done_cnt),   64'd0);
        xv = rand_vec();
        launch(xv, t0);
        wait_cyc(N + 5);
        check_run("t3", xv, g_ref, t0, 1'b0);

        // Missing valid in a write-pair cycle sets sticky err
        xv = rand_vec();
        launch(xv, t0);
        wait_cyc(4);
        kill_valid = 1'b1;
        wait_cyc(1);
        kill_valid = 1'b0;
        check("t4.err_set", 64'(err), 64'd1);
        wait_cyc(3);
        check("t4.done_now", 64'(done), 64'd1);
        check("t4.err_done", 64'(err),  64'd1);
        wait_cyc(N - 3);
        check_run("t4", xv, g_ref, t0, 1'b1);

        // Gamma written in the same cycle as start, random data
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < N; c++) s_mem[c] = rand_vec();
            xv = rand_vec();
            g_new = $urandom;
            cfg_gamma = g_new;
            cfg_gamma_we = 1'b1;
            launch(xv, t0);
            cfg_gamma_we = 1'b0;
            check($sformatf("t5.%0d.err_clr", it), 64'(err),       64'd0);
            check($sformatf("t5.%0d.gamma", it),   64'(spg_gamma), 64'(g_new));
            wait_cyc(N + 5);
            check_run($sformatf("t5.%0d", it), xv, g_new, t0, 1'b0);
            g_ref = g_new;
        end

        // Gamma write while busy is ignored
        xv = rand_vec();
        launch(xv, t0);
        wait_cyc(3);
        cfg_gamma = 32'h0200_0000;
        cfg_gamma_we = 1'b1;
        wait_cyc(1);
        cfg_gamma_we = 1'b0;
        check("t6.gamma_hold", 64'(spg_gamma), 64'(g_ref));
        wait_cyc(N + 1);
        check_run("t6", xv, g_ref, t0, 1'b0);
        check("t6.gamma_after", 64'(spg_gamma), 64'(g_ref));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
